// File: rtl/serial_seq_gen_pkg.sv
// rtl/serial_seq_gen_pkg.sv - shared types and sizing helpers for the serial sequence generator
package serial_seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int bit_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int frame_len(input int width);
`ifdef SERIAL_SEQ_GEN_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/seq_gen_down_counter.sv
// rtl/seq_gen_down_counter.sv - loadable down-counter with zero flag, saturating at zero
module seq_gen_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/serial_sequence_generator_fsm.sv
// rtl/serial_sequence_generator_fsm.sv - serial pattern source, MSB first; SERIAL_SEQ_GEN_PARITY_EN appends an even-parity bit
module serial_sequence_generator_fsm
    import serial_seq_gen_pkg::*;
#(
    parameter int WIDTH      = 6,
    parameter int GAP_CYCLES = 0,
    parameter int REPS_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  pattern_in,
    input  logic [REPS_W-1:0] reps_in,
    output logic              busy,
    output logic              a,
    output logic              a_valid,
    output logic              done
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int CNT_W = (bit_cnt_w(WIDTH) > GAP_W) ? bit_cnt_w(WIDTH) : GAP_W;
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_pat, w_pat_nxt;
    logic [WIDTH-1:0]  r_shift, w_shift_nxt;
    logic              r_a, w_a_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_done, w_done_nxt;
    logic              r_busy, w_busy_nxt;

    logic              w_bit_load, w_bit_dec, w_bit_zero;
    logic [CNT_W-1:0]  w_bit_load_val;
    logic              w_rep_load, w_rep_dec, w_rep_zero;
    logic [REPS_W-1:0] w_rep_load_val;

`ifdef SERIAL_SEQ_GEN_PARITY_EN
    logic              r_par_sent, w_par_sent_nxt;
`endif

    // The rep counter holds repetitions still to go after the current one, so 0 and 1 both mean one frame.
    assign w_rep_load_val = (reps_in == '0) ? '0 : reps_in - REPS_W'(1);

    seq_gen_down_counter #(.W(CNT_W)) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_bit_load),
        .i_load_val (w_bit_load_val),
        .i_dec      (w_bit_dec),
        .o_zero     (w_bit_zero)
    );

    seq_gen_down_counter #(.W(REPS_W)) u_rep_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_rep_load),
        .i_load_val (w_rep_load_val),
        .i_dec      (w_rep_dec),
        .o_zero     (w_rep_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_shift <= '0;
            r_a     <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_shift <= w_shift_nxt;
            r_a     <= w_a_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef SERIAL_SEQ_GEN_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_sent <= 1'b0;
        end else begin
            r_par_sent <= w_par_sent_nxt;
        end
    end
`endif

    // Outputs are computed for the next cycle and registered, so a/a_valid track the state being entered.
    always_comb begin
        w_state_nxt    = r_state;
        w_pat_nxt      = r_pat;
        w_shift_nxt    = r_shift;
        w_a_nxt        = 1'b0;
        w_valid_nxt    = 1'b0;
        w_done_nxt     = 1'b0;
        w_bit_load     = 1'b0;
        w_bit_load_val = BIT_LOAD;
        w_bit_dec      = 1'b0;
        w_rep_load     = 1'b0;
        w_rep_dec      = 1'b0;
`ifdef SERIAL_SEQ_GEN_PARITY_EN
        w_par_sent_nxt = r_par_sent;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SHIFT;
                    w_pat_nxt   = pattern_in;
                    w_a_nxt     = pattern_in[WIDTH-1];
                    w_shift_nxt = {pattern_in[WIDTH-2:0], 1'b0};
                    w_valid_nxt = 1'b1;
                    w_bit_load  = 1'b1;
                    w_rep_load  = 1'b1;
`ifdef SERIAL_SEQ_GEN_PARITY_EN
                    w_par_sent_nxt = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (!w_bit_zero) begin
                    w_a_nxt     = r_shift[WIDTH-1];
                    w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
                    w_valid_nxt = 1'b1;
                    w_bit_dec   = 1'b1;
`ifdef SERIAL_SEQ_GEN_PARITY_EN
                end else if (!r_par_sent) begin
                    w_a_nxt        = ^r_pat;
                    w_valid_nxt    = 1'b1;
                    w_par_sent_nxt = 1'b1;
`endif
                end else if (!w_rep_zero) begin
                    w_rep_dec  = 1'b1;
                    w_bit_load = 1'b1;
`ifdef SERIAL_SEQ_GEN_PARITY_EN
                    w_par_sent_nxt = 1'b0;
`endif
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt    = GAP;
                        w_shift_nxt    = r_pat;
                        w_bit_load_val = GAP_LOAD;
                    end else begin
                        w_a_nxt     = r_pat[WIDTH-1];
                        w_shift_nxt = {r_pat[WIDTH-2:0], 1'b0};
                        w_valid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (w_bit_zero) begin
                    w_state_nxt = SHIFT;
                    w_a_nxt     = r_pat[WIDTH-1];
                    w_shift_nxt = {r_pat[WIDTH-2:0], 1'b0};
                    w_valid_nxt = 1'b1;
                    w_bit_load  = 1'b1;
                end else begin
                    w_bit_dec = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign busy    = r_busy;
    assign a       = r_a;
    assign a_valid = r_valid;
    assign done    = r_done;

endmodule

// File: tb/tb_serial_sequence_generator_fsm.sv
// tb/tb_serial_sequence_generator_fsm.sv - table-driven bench for serial_sequence_generator_fsm
module tb_serial_sequence_generator_fsm;

    localparam int W = 6;
`ifdef SERIAL_SEQ_GEN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FL = W + PAR;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start_g;
    logic [5:0] pattern_in;
    logic [3:0] reps_in;
    logic       busy0, a0, av0, done0;
    logic       busy_g, a_g, av_g, done_g;
    logic       sel;
    logic       s_busy, s_a, s_av, s_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_sequence_generator_fsm #(.WIDTH(W), .GAP_CYCLES(0), .REPS_W(4)) dut (
        .clk(clk), .rst(rst), .start(start0), .pattern_in(pattern_in), .reps_in(reps_in),
        .busy(busy0), .a(a0), .a_valid(av0), .done(done0)
    );

    serial_sequence_generator_fsm #(.WIDTH(W), .GAP_CYCLES(2), .REPS_W(4)) dut_g (
        .clk(clk), .rst(rst), .start(start_g), .pattern_in(pattern_in), .reps_in(reps_in),
        .busy(busy_g), .a(a_g), .a_valid(av_g), .done(done_g)
    );

    assign s_busy = sel ? busy_g : busy0;
    assign s_a    = sel ? a_g    : a0;
    assign s_av   = sel ? av_g   : av0;
    assign s_done = sel ? done_g : done0;

    typedef struct {
        logic [5:0] pat;
        logic [3:0] reps;
        bit         gap;
        bit         poke;
        int         exp_done;
        int         exp_done_par;
        int         exp_hits;
        int         exp_hits_par;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input logic [5:0] pat, input logic [3:0] reps, input bit gap,
                       input bit poke, input int exp_done, input int exp_hits, input string tag);
        logic [127:0] ev, ea, gv, ga;
        logic [5:0]   win;
        int r_eff, g, c, done_cnt, done_cyc, busy_cnt, idle_cyc, nb, hits, hit_cyc;
        bit finished;
        ev = '0; ea = '0; gv = '0; ga = '0;
        r_eff = (reps == 0) ? 1 : int'(reps);
        g = gap ? 2 : 0;
        c = 1;
        for (int r = 0; r < r_eff; r++) begin
            for (int i = 0; i < FL; i++) begin
                ev[c] = 1'b1;
                ea[c] = (i < W) ? pat[W-1-i] : ^pat;
                c++;
            end
            if (r < r_eff - 1) c += g;
        end
        sel = gap;
        @(negedge clk);
        pattern_in = pat;
        reps_in    = reps;
        if (gap) start_g = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start_g = 1'b0;
        pattern_in = 6'h2a; reps_in = 4'd9;
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; idle_cyc = -1;
        nb = 0; hits = 0; hit_cyc = -1; win = '0;
        finished = 1'b0;
        for (int cy = 1; cy < 100; cy++) begin
            gv[cy] = s_av;
            ga[cy] = s_a;
            if (s_av) begin
                win = {win[4:0], s_a};
                nb++;
                if (nb >= 6 && win == 6'b110011) begin
                    hits++;
                    hit_cyc = cy;
                end
            end
            if (s_done) begin
                done_cnt++;
                done_cyc = cy;
            end
            if (s_busy) busy_cnt++;
            else begin
                idle_cyc = cy;
                finished = 1'b1;
                break;
            end
            if (poke && (cy == 3 || cy == 7)) begin
                pattern_in = ~pat;
                reps_in    = 4'd5;
                if (gap) start_g = 1'b1; else start0 = 1'b1;
            end
            @(negedge clk);
            start0 = 1'b0; start_g = 1'b0;
        end
        chk({tag, "_terminated"}, int'(finished), 1);
        chk_vec({tag, "_valid_trace"}, gv, ev);
        chk_vec({tag, "_data_trace"}, ga, ea);
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_len"}, busy_cnt, exp_done);
        chk({tag, "_idle_cycle"}, idle_cyc, exp_done + 1);
        chk({tag, "_det_hits"}, hits, exp_hits);
        if (exp_hits == 1 && r_eff == 1) chk({tag, "_det_last_bit"}, hit_cyc, W);
    endtask

    initial begin
        tbl[0] = '{6'b110011, 4'd1, 1'b0, 1'b0,  7,  8, 1, 1};
        tbl[1] = '{6'b110010, 4'd1, 1'b0, 1'b0,  7,  8, 0, 0};
        tbl[2] = '{6'b101101, 4'd3, 1'b1, 1'b0, 23, 26, 0, 0};
        tbl[3] = '{6'b110011, 4'd0, 1'b0, 1'b0,  7,  8, 1, 1};
        tbl[4] = '{6'b100001, 4'd2, 1'b0, 1'b0, 13, 15, 0, 0};
        tbl[5] = '{6'b011110, 4'd2, 1'b1, 1'b0, 15, 17, 1, 0};
        tbl[6] = '{6'b110011, 4'd1, 1'b0, 1'b1,  7,  8, 1, 1};

        sel = 1'b0;
        rst = 1'b1; start0 = 1'b0; start_g = 1'b0;
        pattern_in = '0; reps_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   int'(busy0),  0);
        chk("reset_a",      int'(a0),     0);
        chk("reset_valid",  int'(av0),    0);
        chk("reset_done",   int'(done0),  0);
        chk("reset_busy_g", int'(busy_g), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run(tbl[i].pat, tbl[i].reps, tbl[i].gap, tbl[i].poke,
                (PAR != 0) ? tbl[i].exp_done_par : tbl[i].exp_done,
                (PAR != 0) ? tbl[i].exp_hits_par : tbl[i].exp_hits,
                $sformatf("vec%0d", i));
        end

        // Reset in cycle 4 of a frame, then a fresh frame started in cycle 6.
        sel = 1'b0;
        @(negedge clk);
        pattern_in = 6'b110011; reps_in = 4'd1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_a",     int'(a0),    0);
        chk("midrst_valid", int'(av0),   0);
        chk("midrst_busy",  int'(busy0), 0);
        chk("midrst_done",  int'(done0), 0);
        run(6'b110011, 4'd1, 1'b0, 1'b0, 7 + PAR, 1, "after_rst");

        // rst and start in the same cycle: start is dropped.
        @(negedge clk);
        rst = 1'b1; start0 = 1'b1; pattern_in = 6'b111111; reps_in = 4'd1;
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0;
        chk("rst_start_busy",  int'(busy0), 0);
        @(negedge clk);
        chk("rst_start_valid", int'(av0),   0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
